// File: rtl/sccb_target.sv
// SCCB (OV7670-compatible) register-bus target. SIOC/SIOD are oversampled in the
// clk domain; writes emit a one-cycle strobe and reads are served from an external bank.
module sccb_target #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc_in,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       rd_strobe,
  output logic       busy
);
  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    IDLE, ID, ID_X, SUB, SUB_X, WDATA, WDATA_X, RDATA, RDATA_X, IGNORE
  } state_t;

  state_t           state_q, state_d;
  logic [NSYNC-1:0] sioc_sync_q, sioc_sync_d;
  logic [NSYNC-1:0] siod_sync_q, siod_sync_d;
  logic             sioc_dly_q, sioc_dly_d;
  logic             siod_dly_q, siod_dly_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       tx_q, tx_d;
  logic             x_rise_q, x_rise_d;
  logic             rw_q, rw_d;
  logic             siod_oe_q, siod_oe_d;
  logic             wr_valid_q, wr_valid_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       rd_addr_q, rd_addr_d;
  logic             rd_strobe_q, rd_strobe_d;
  logic             busy_q, busy_d;

  logic       sioc_s, siod_s;
  logic       sioc_rise, sioc_fall, start_det, stop_det;
  logic [7:0] byte_in;

  assign sioc_s    = sioc_sync_q[NSYNC-1];
  assign siod_s    = siod_sync_q[NSYNC-1];
  assign sioc_rise = sioc_s & ~sioc_dly_q;
  assign sioc_fall = ~sioc_s & sioc_dly_q;
  // SIOC must be steadily high so a data change coinciding with a clock edge never looks like START/STOP
  assign start_det = sioc_s & sioc_dly_q & siod_dly_q & ~siod_s;
  assign stop_det  = sioc_s & sioc_dly_q & ~siod_dly_q & siod_s;
  assign byte_in   = {shift_q, siod_s};

  always_comb begin
    sioc_sync_d = {sioc_sync_q[NSYNC-2:0], sioc_in};
    siod_sync_d = {siod_sync_q[NSYNC-2:0], siod_in};
    sioc_dly_d  = sioc_s;
    siod_dly_d  = siod_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    x_rise_d    = x_rise_q;
    rw_d        = rw_q;
    siod_oe_d   = siod_oe_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    rd_strobe_d = 1'b0;
    busy_d      = busy_q;

    if (start_det) begin
      state_d   = ID;
      cnt_d     = 3'd0;
      x_rise_d  = 1'b0;
      siod_oe_d = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      cnt_d     = 3'd0;
      x_rise_d  = 1'b0;
      siod_oe_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ID, SUB, WDATA: begin
          if (sioc_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              x_rise_d = 1'b0;
              if (state_q == ID) begin
                if (byte_in[7:1] != DEV_ID[7:1]) begin
                  state_d = IGNORE;
                end else begin
                  state_d = ID_X;
                  rw_d    = byte_in[0];
                end
              end else if (state_q == SUB) begin
                rd_addr_d = byte_in;
                state_d   = SUB_X;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = rd_addr_q;
                wr_data_d  = byte_in;
                state_d    = WDATA_X;
              end
            end
          end
        end
        RDATA: begin
          if (sioc_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d  = RDATA_X;
              x_rise_d = 1'b0;
            end
          end else if (sioc_fall) begin
            siod_oe_d = ~tx_q[3'd7 - cnt_q];
          end
        end
        // First fall opens the 9th bit (ACK driven, or released for the master's NA);
        // second fall closes it and hands over to the next phase.
        ID_X, SUB_X, WDATA_X, RDATA_X: begin
          if (sioc_rise) begin
            x_rise_d = 1'b1;
          end else if (sioc_fall) begin
            if (!x_rise_q) begin
              siod_oe_d = (state_q != RDATA_X);
            end else begin
              siod_oe_d = 1'b0;
              x_rise_d  = 1'b0;
              cnt_d     = 3'd0;
              if (state_q == ID_X) begin
                if (rw_q) begin
                  state_d     = RDATA;
                  tx_d        = rd_data;
                  rd_strobe_d = 1'b1;
                  siod_oe_d   = ~rd_data[7];
                end else begin
                  state_d = SUB;
                end
              end else if (state_q == SUB_X) begin
                state_d = WDATA;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        default: siod_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_dly_q  <= 1'b1;
      siod_dly_q  <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      x_rise_q    <= 1'b0;
      rw_q        <= 1'b0;
      siod_oe_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      rd_addr_q   <= 8'h00;
      rd_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sioc_sync_q <= sioc_sync_d;
      siod_sync_q <= siod_sync_d;
      sioc_dly_q  <= sioc_dly_d;
      siod_dly_q  <= siod_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_rise_q    <= x_rise_d;
      rw_q        <= rw_d;
      siod_oe_q   <= siod_oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
      rd_strobe_q <= rd_strobe_d;
      busy_q      <= busy_d;
    end
  end

  // Shift/transmit registers are always fully reloaded before use
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    tx_q    <= tx_d;
  end

  assign siod_oe   = siod_oe_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB master on a wired-AND SIOD, register bank,
// and a transaction-level reference model of acks, writes, read data and pointer.
module tb_sccb_target;
  localparam int         Q      = 5;
  localparam logic [7:0] DEV_ID = 8'h42;

  logic       clk = 1'b0;
  logic       rst_n, scl, sda_m;
  logic       siod_in, siod_oe, wr_valid, rd_strobe, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] bank [256];

  always #5 clk = ~clk;
  assign siod_in = sda_m & ~siod_oe;
  assign rd_data = bank[rd_addr];

  sccb_target #(.DEV_ID(DEV_ID), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sioc_in(scl), .siod_in(siod_in), .siod_oe(siod_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_strobe(rd_strobe), .busy(busy)
  );

  int          n_cmp = 0, n_err = 0;
  logic [15:0] act_wr [$];
  logic [15:0] exp_wr [$];
  int          n_rdstb = 0, exp_rdstb = 0;
  logic [7:0]  ptr_m = 8'h00;
  logic [7:0]  txb [8];
  logic        obs_ack [8], obs_oe [8], exp_ack [8];
  logic [7:0]  obs_rv [8], exp_rv [8];

  always @(negedge clk) begin
    if (wr_valid) act_wr.push_back({wr_addr, wr_data});
    if (rd_strobe) n_rdstb++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master ----------------
  task automatic q(); repeat (Q) @(negedge clk); endtask

  task automatic m_start();
    sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q(); scl = 1'b0; q();
  endtask

  task automatic m_stop();
    q(); sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q(); q();
  endtask

  task automatic m_bit(input logic b, output logic rd, output logic oe);
    q(); sda_m = b; q(); scl = 1'b1; q(); rd = siod_in; oe = siod_oe; q(); scl = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] d, output logic [7:0] rv, output logic oe_any,
                        output logic ack_oe);
    logic r, o;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      m_bit(d[i], r, o);
      rv[i] = r;
      oe_any = oe_any | o;
    end
    m_bit(1'b1, r, ack_oe);
  endtask

  task automatic run_txn(input logic [7:0] id, input int n, input bit do_stop);
    logic [7:0] d;
    m_start();
    m_byte(id, obs_rv[0], obs_oe[0], obs_ack[0]);
    for (int i = 1; i <= n; i++) begin
      d = id[0] ? 8'hFF : txb[i-1];
      m_byte(d, obs_rv[i], obs_oe[i], obs_ack[i]);
    end
    if (do_stop) m_stop();
  endtask

  // ---------------- reference model ----------------
  function automatic void model_txn(input logic [7:0] id, input int n);
    bit match = (id[7:1] == DEV_ID[7:1]);
    for (int i = 0; i < 8; i++) begin
      exp_ack[i] = 1'b0;
      exp_rv[i]  = 8'hFF;
    end
    exp_ack[0] = match;
    if (match && !id[0]) begin
      if (n >= 1) begin exp_ack[1] = 1'b1; ptr_m = txb[0]; end
      if (n >= 2) begin exp_ack[2] = 1'b1; exp_wr.push_back({ptr_m, txb[1]}); end
    end else if (match) begin
      exp_rdstb++;
      if (n >= 1) exp_rv[1] = bank[ptr_m];
    end
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (siod_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe: got %b want 0", siod_oe); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (wr_valid !== 1'b0 || rd_strobe !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes: got wr=%b rd=%b want 0 0", wr_valid, rd_strobe); end
    n_cmp++; if ({wr_addr, wr_data, rd_addr} !== 24'h0) begin
      n_err++; $display("FAIL reset_regs: got %h want 000000", {wr_addr, wr_data, rd_addr}); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || siod_oe !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: got busy=%b oe=%b want 0 0", busy, siod_oe); end
  endtask

  task automatic test_write_basic();
    txb[0] = 8'h12; txb[1] = 8'h80;
    model_txn(DEV_ID, 2);
    run_txn(DEV_ID, 2, 1'b0);
    for (int i = 0; i <= 2; i++) begin
      n_cmp++; if (obs_ack[i] !== exp_ack[i]) begin
        n_err++; $display("FAIL wb_ack[%0d]: got %b want %b", i, obs_ack[i], exp_ack[i]); end
      n_cmp++; if (obs_oe[i] !== 1'b0) begin
        n_err++; $display("FAIL wb_data_oe[%0d]: got %b want 0", i, obs_oe[i]); end
    end
    q(); sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wb_busy_at_stop: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wb_busy_after_stop: got %b want 0", busy); end
    q();
    n_cmp++; if (act_wr.size() != exp_wr.size()) begin
      n_err++; $display("FAIL wb_wr_count: got %0d want %0d", act_wr.size(), exp_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_cmp++; if (act_wr[i] !== exp_wr[i]) begin
        n_err++; $display("FAIL wb_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    act_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_wrong_id();
    txb[0] = 8'h33; txb[1] = 8'h44;
    model_txn(8'h60, 2);
    run_txn(8'h60, 2, 1'b0);
    for (int i = 0; i <= 2; i++) begin
      n_cmp++; if (obs_ack[i] !== exp_ack[i] || obs_oe[i] !== 1'b0) begin
        n_err++; $display("FAIL wid_oe[%0d]: got ack=%b oe=%b want %b 0", i, obs_ack[i], obs_oe[i], exp_ack[i]); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wid_busy: got %b want 1", busy); end
    m_stop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wid_busy_stop: got %b want 0", busy); end
    n_cmp++; if (act_wr.size() != 0) begin n_err++; $display("FAIL wid_wr_count: got %0d want 0", act_wr.size()); end
    act_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_read();
    txb[0] = 8'h0A;
    model_txn(DEV_ID, 1);
    run_txn(DEV_ID, 1, 1'b1);
    n_cmp++; if (rd_addr !== ptr_m) begin n_err++; $display("FAIL rd_ptr: got %h want %h", rd_addr, ptr_m); end
    n_cmp++; if (act_wr.size() != 0) begin n_err++; $display("FAIL rd_2phase_wr: got %0d want 0", act_wr.size()); end
    bank[8'h0A] = 8'h76;
    n_rdstb = 0; exp_rdstb = 0;
    model_txn(DEV_ID | 8'h01, 1);
    run_txn(DEV_ID | 8'h01, 1, 1'b1);
    n_cmp++; if (obs_ack[0] !== exp_ack[0]) begin n_err++; $display("FAIL rd_id_ack: got %b want %b", obs_ack[0], exp_ack[0]); end
    n_cmp++; if (obs_rv[1] !== exp_rv[1]) begin n_err++; $display("FAIL rd_data: got %h want %h", obs_rv[1], exp_rv[1]); end
    n_cmp++; if (obs_ack[1] !== 1'b0) begin n_err++; $display("FAIL rd_na_release: got %b want 0", obs_ack[1]); end
    n_cmp++; if (n_rdstb != exp_rdstb) begin n_err++; $display("FAIL rd_strobe_count: got %0d want %0d", n_rdstb, exp_rdstb); end
    act_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_restart();
    logic [7:0] rv; logic o, a, r;
    m_start();
    m_byte(DEV_ID, rv, o, a);
    m_byte(8'h55, rv, o, a);
    ptr_m = 8'h55;
    for (int i = 0; i < 5; i++) m_bit(i[0], r, o);
    txb[0] = 8'h3A; txb[1] = 8'h04;
    model_txn(DEV_ID, 2);
    run_txn(DEV_ID, 2, 1'b1);
    n_cmp++; if (act_wr.size() != exp_wr.size()) begin
      n_err++; $display("FAIL rs_wr_count: got %0d want %0d", act_wr.size(), exp_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_cmp++; if (act_wr[i] !== exp_wr[i]) begin
        n_err++; $display("FAIL rs_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    n_cmp++; if (rd_addr !== ptr_m) begin n_err++; $display("FAIL rs_ptr: got %h want %h", rd_addr, ptr_m); end
    act_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rv; logic o, a;
    bank[ptr_m] = 8'h00;
    m_start();
    m_byte(DEV_ID | 8'h01, rv, o, a);
    q();
    n_cmp++; if (siod_oe !== 1'b1) begin n_err++; $display("FAIL rr_oe_before: got %b want 1", siod_oe); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (siod_oe !== 1'b0) begin n_err++; $display("FAIL rr_oe_released: got %b want 0", siod_oe); end
    n_cmp++; if (rd_addr !== 8'h00 || busy !== 1'b0) begin
      n_err++; $display("FAIL rr_regs: got rd_addr=%h busy=%b want 00 0", rd_addr, busy); end
    rst_n = 1'b1;
    ptr_m = 8'h00;
    m_stop();
    act_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_back_to_back();
    txb[0] = 8'h12; txb[1] = 8'h80;
    model_txn(DEV_ID, 2);
    run_txn(DEV_ID, 2, 1'b0);
    txb[0] = 8'h11; txb[1] = 8'h01;
    for (int i = 2; i < 6; i++) txb[i] = 8'($urandom);
    model_txn(DEV_ID, 6);
    run_txn(DEV_ID, 6, 1'b1);
    for (int i = 0; i <= 6; i++) begin
      n_cmp++; if (obs_ack[i] !== exp_ack[i]) begin
        n_err++; $display("FAIL bb_ack[%0d]: got %b want %b", i, obs_ack[i], exp_ack[i]); end
    end
    n_cmp++; if (act_wr.size() != exp_wr.size()) begin
      n_err++; $display("FAIL bb_wr_count: got %0d want %0d", act_wr.size(), exp_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_cmp++; if (act_wr[i] !== exp_wr[i]) begin
        n_err++; $display("FAIL bb_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    act_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_random();
    logic [7:0] id; int n; bit st;
    for (int i = 0; i < 256; i++) bank[i] = 8'($urandom);
    n_rdstb = 0; exp_rdstb = 0;
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 3))
        0, 1:    id = DEV_ID;
        2:       id = DEV_ID | 8'h01;
        default: id = 8'($urandom);
      endcase
      n  = id[0] ? $urandom_range(1, 2) : $urandom_range(0, 4);
      st = (t == 24) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) txb[i] = 8'($urandom);
      model_txn(id, n);
      run_txn(id, n, st);
      for (int i = 0; i <= n; i++) begin
        n_cmp++; if (obs_ack[i] !== exp_ack[i]) begin
          n_err++; $display("FAIL rnd%0d_ack[%0d] id=%h: got %b want %b", t, i, id, obs_ack[i], exp_ack[i]); end
        if (!id[0] || i == 0) begin
          n_cmp++; if (obs_oe[i] !== 1'b0) begin
            n_err++; $display("FAIL rnd%0d_oe[%0d] id=%h: got %b want 0", t, i, id, obs_oe[i]); end
        end else begin
          n_cmp++; if (obs_rv[i] !== exp_rv[i]) begin
            n_err++; $display("FAIL rnd%0d_rdata[%0d] id=%h: got %h want %h", t, i, id, obs_rv[i], exp_rv[i]); end
        end
      end
      n_cmp++; if (rd_addr !== ptr_m) begin
        n_err++; $display("FAIL rnd%0d_ptr: got %h want %h", t, rd_addr, ptr_m); end
    end
    q();
    n_cmp++; if (act_wr.size() != exp_wr.size()) begin
      n_err++; $display("FAIL rnd_wr_count: got %0d want %0d", act_wr.size(), exp_wr.size()); end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_cmp++; if (act_wr[i] !== exp_wr[i]) begin
        n_err++; $display("FAIL rnd_wr[%0d]: got %h want %h", i, act_wr[i], exp_wr[i]); end
    end
    n_cmp++; if (n_rdstb != exp_rdstb) begin
      n_err++; $display("FAIL rnd_rd_strobe_count: got %0d want %0d", n_rdstb, exp_rdstb); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_busy_end: got %b want 0", busy); end
    act_wr.delete(); exp_wr.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bank[i] = 8'h00;
    test_reset();
    test_write_basic();
    test_wrong_id();
    test_read();
    test_restart();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB (OV7670-compatible) target/responder. It is the far end of the camera register-configuration bus.
- Lets a camera-emulation or loopback design receive the configuration writes the FPGA master issues on SIOC/SIOD, and answer register reads.
- Oversamples SIOC/SIOD in the system clock domain. Emits one write strobe per 3-phase write and serves read data from an external register bank.

Parameters:
- DEV_ID, 8'h42, 8-bit write ID. Bit 0 is ignored for matching; the read ID is DEV_ID|1.
- SYNC_STAGES, 2, synchroniser flops on sioc_in/siod_in (minimum 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sioc_in  in  1  SCCB clock from the bus.
- siod_in  in  1  SCCB data sampled from the bus.
- siod_oe  out  1  1 = pull SIOD low (open-drain); 0 = release.
- wr_valid  out  1  one-cycle pulse: register write committed.
- wr_addr  out  8  sub-address of the committed write.
- wr_data  out  8  data of the committed write.
- rd_addr  out  8  current read pointer (last received sub-address).
- rd_data  in  8  register contents at rd_addr; combinational from the bank.
- rd_strobe  out  1  one-cycle pulse when rd_data is captured for transmission.
- busy  out  1  1 from START to STOP or abort.

Behaviour:

Reset:
- siod_oe, wr_valid, rd_strobe and busy are 0.
- wr_addr, wr_data and rd_addr are 8'h00.
- State is IDLE; synchroniser and edge flops load 1 (idle bus).

Sampling and edges:
- sioc_s/siod_s come out of SYNC_STAGES flops, plus one delay flop for edge detection.
- START: siod_s falls while sioc_s is high, in any state.
- STOP: siod_s rises while sioc_s is high.
- Bits are sampled on sioc_s rising and shifted MSB first.
- siod_oe changes only in the cycle a sioc_s falling edge is detected.
- Requirement: clk ≥ 8× SIOC frequency.

States: IDLE, ID, ID_X, SUB, SUB_X, WDATA, WDATA_X, RDATA, RDATA_X, IGNORE.
- A 3-bit counter counts 8 bits per phase.
- START from any state → ID; counter cleared, siod_oe=0, busy=1. A repeated start is legal.
- STOP from any state → IDLE; siod_oe=0, busy=0.

Transitions:
- ID → ID_X after 8 bits.
  - If id[7:1]≠DEV_ID[7:1] → IGNORE, no ACK driven.
  - Otherwise drive ACK: siod_oe=1 from the falling edge after bit 8 to the falling edge after the 9th clock.
- ID_X with R/W=0 → SUB. With R/W=1 → RDATA.
- SUB → SUB_X after 8 bits: latch rd_addr, drive ACK, → WDATA.
  - A STOP after SUB_X is a 2-phase write: the pointer is set and no write occurs.
- WDATA:
  - On the 8th sampled bit, pulse wr_valid for 1 cycle with wr_addr=rd_addr and wr_data=byte.
  - Then WDATA_X with ACK, → IGNORE.
  - Extra bytes: no auto-increment, no write.
- RDATA entry (falling edge ending ID_X): capture rd_data and pulse rd_strobe.
  - siod_oe = ~bit7, then ~next bit on each subsequent SIOC falling edge.
- After 8 bits release siod_oe and go to RDATA_X, which samples the master NA bit (ignored), → IGNORE.
- IGNORE: siod_oe=0; wait for START/STOP.

Abort and reset rules:
- START/STOP mid-byte discards the partial byte. wr_valid never fires for an incomplete data byte.
- rd_addr is kept across transactions; it changes only on SUB_X or reset.
- rst_n low mid-transaction: next cycle all outputs are at reset values and siod_oe is released immediately.

Test Plan:
- 3-phase write ID 0x42, sub 0x12, data 0x80 → one wr_valid pulse with wr_addr=0x12, wr_data=0x80; siod_oe=1 during each of the 3 X bits; busy falls 1 cycle after STOP detection.
- ID 0x60 followed by two bytes → no siod_oe assertion and no wr_valid; busy stays 1 until STOP.
- 2-phase write sub 0x0A, STOP, then read ID 0x43 with bank returning 0x76 → rd_addr=0x0A, one rd_strobe, SIOD bit pattern 0,1,1,1,0,1,1,0 (oe=~bit), oe released at the NA bit.
- Repeated START after bit 5 of the data byte, then a full write sub 0x3A data 0x04 → only one wr_valid, with addr 0x3A and data 0x04.
- rst_n low during RDATA with siod_oe=1 → siod_oe=0 next cycle; state IDLE; rd_addr=0x00.
- Write 0x12/0x80 then 0x11/0x01 back-to-back, with data 4 extra bytes after the second → exactly two wr_valid pulses; extra bytes neither ACKed nor written.
